// File: rtl/conv_frame_sequencer.sv
// Frame sequencer for 14x14 IFM / 3x3 conv / 2x2 pool: load 196 beats, step 144 conv windows, 36 pool windows.
// Only LOAD can stall (on in_valid); CONV/POOL/DRAIN run one step per cycle and drop input.
module conv_frame_sequencer #(
    parameter int OUT_LAT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       ifm_wr_en,
    output logic [7:0] ifm_wr_addr,
    output logic       wgt_wr_en,
    output logic [3:0] wgt_wr_addr,
    output logic       conv_en,
    output logic [7:0] conv_base,
    output logic [7:0] ofm_wr_addr,
    output logic       pool_en,
    output logic [7:0] pool_base,
    output logic [5:0] pool_idx,
    output logic       out_valid,
    output logic       frame_done,
    output logic       busy
);
    localparam int DW = (OUT_LAT > 1) ? $clog2(OUT_LAT) : 1;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CONV, S_POOL, S_DRAIN} state_t;

    state_t             state_q, state_d;
    logic [7:0]         beat_q, beat_d;
    logic [3:0]         row_q, row_d, col_q, col_d;
    logic [7:0]         cbase_q, cbase_d, ofm_q, ofm_d;
    logic [2:0]         prow_q, prow_d, pcol_q, pcol_d;
    logic [7:0]         pbase_q, pbase_d;
    logic [5:0]         pidx_q, pidx_d;
    logic [DW-1:0]      drain_q, drain_d;
    logic [OUT_LAT-1:0] dly_q, dly_d;

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        row_d    = row_q;
        col_d    = col_q;
        cbase_d  = cbase_q;
        ofm_d    = ofm_q;
        prow_d   = prow_q;
        pcol_d   = pcol_q;
        pbase_d  = pbase_q;
        pidx_d   = pidx_q;
        drain_d  = drain_q;
        in_ready = (state_q == S_IDLE) || (state_q == S_LOAD);
        conv_en  = (state_q == S_CONV);
        pool_en  = (state_q == S_POOL);
        busy     = (state_q != S_IDLE);
        ifm_wr_en  = in_valid && in_ready;
        wgt_wr_en  = ifm_wr_en && (beat_q < 8'd9);
        frame_done = (state_q == S_DRAIN) && (drain_q == DW'(OUT_LAT - 1));

        case (state_q)
            S_IDLE, S_LOAD: begin
                if (ifm_wr_en) begin
                    if (beat_q == 8'd195) begin
                        beat_d  = '0;
                        state_d = S_CONV;
                    end else begin
                        beat_d  = beat_q + 8'd1;
                        state_d = S_LOAD;
                    end
                end
            end
            S_CONV: begin
                // Window base tracks r*14+c incrementally: +1 along a row, +3 on row wrap.
                ofm_d = ofm_q + 8'd1;
                if (col_q == 4'd11) begin
                    col_d   = '0;
                    cbase_d = cbase_q + 8'd3;
                    if (row_q == 4'd11) begin
                        row_d   = '0;
                        cbase_d = '0;
                        ofm_d   = '0;
                        state_d = S_POOL;
                    end else begin
                        row_d = row_q + 4'd1;
                    end
                end else begin
                    col_d   = col_q + 4'd1;
                    cbase_d = cbase_q + 8'd1;
                end
            end
            S_POOL: begin
                // Pool base tracks pr*24+pc*2: +2 along a row, +14 on row wrap.
                pidx_d = pidx_q + 6'd1;
                if (pcol_q == 3'd5) begin
                    pcol_d  = '0;
                    pbase_d = pbase_q + 8'd14;
                    if (prow_q == 3'd5) begin
                        prow_d  = '0;
                        pbase_d = '0;
                        pidx_d  = '0;
                        state_d = S_DRAIN;
                    end else begin
                        prow_d = prow_q + 3'd1;
                    end
                end else begin
                    pcol_d  = pcol_q + 3'd1;
                    pbase_d = pbase_q + 8'd2;
                end
            end
            S_DRAIN: begin
                if (drain_q == DW'(OUT_LAT - 1)) begin
                    drain_d = '0;
                    state_d = S_IDLE;
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        dly_d[0] = pool_en;
        for (int i = 1; i < OUT_LAT; i++) begin
            dly_d[i] = dly_q[i-1];
        end
    end

    assign ifm_wr_addr = ifm_wr_en ? beat_q : 8'd0;
    assign wgt_wr_addr = wgt_wr_en ? beat_q[3:0] : 4'd0;
    assign conv_base   = conv_en ? cbase_q : 8'd0;
    assign ofm_wr_addr = conv_en ? ofm_q : 8'd0;
    assign pool_base   = pool_en ? pbase_q : 8'd0;
    assign pool_idx    = pool_en ? pidx_q : 6'd0;
    assign out_valid   = dly_q[OUT_LAT-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
            cbase_q <= '0;
            ofm_q   <= '0;
            prow_q  <= '0;
            pcol_q  <= '0;
            pbase_q <= '0;
            pidx_q  <= '0;
            drain_q <= '0;
            dly_q   <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            row_q   <= row_d;
            col_q   <= col_d;
            cbase_q <= cbase_d;
            ofm_q   <= ofm_d;
            prow_q  <= prow_d;
            pcol_q  <= pcol_d;
            pbase_q <= pbase_d;
            pidx_q  <= pidx_d;
            drain_q <= drain_d;
            dly_q   <= dly_d;
        end
    end
endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Two instances (OUT_LAT=1 and 3) share one input stream; a frame-level model schedules expected events.
module tb_conv_frame_sequencer;
    logic clk = 1'b0;
    logic rst_n, in_valid;
    always #5 clk = ~clk;

    logic       in_ready_a, ifm_wr_en_a, wgt_wr_en_a, conv_en_a, pool_en_a, out_valid_a, frame_done_a, busy_a;
    logic [7:0] ifm_wr_addr_a, conv_base_a, ofm_wr_addr_a, pool_base_a;
    logic [3:0] wgt_wr_addr_a;
    logic [5:0] pool_idx_a;
    logic       in_ready_b, ifm_wr_en_b, wgt_wr_en_b, conv_en_b, pool_en_b, out_valid_b, frame_done_b, busy_b;
    logic [7:0] ifm_wr_addr_b, conv_base_b, ofm_wr_addr_b, pool_base_b;
    logic [3:0] wgt_wr_addr_b;
    logic [5:0] pool_idx_b;

    conv_frame_sequencer #(.OUT_LAT(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
        .ifm_wr_en(ifm_wr_en_a), .ifm_wr_addr(ifm_wr_addr_a),
        .wgt_wr_en(wgt_wr_en_a), .wgt_wr_addr(wgt_wr_addr_a),
        .conv_en(conv_en_a), .conv_base(conv_base_a), .ofm_wr_addr(ofm_wr_addr_a),
        .pool_en(pool_en_a), .pool_base(pool_base_a), .pool_idx(pool_idx_a),
        .out_valid(out_valid_a), .frame_done(frame_done_a), .busy(busy_a));

    conv_frame_sequencer #(.OUT_LAT(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .ifm_wr_en(ifm_wr_en_b), .ifm_wr_addr(ifm_wr_addr_b),
        .wgt_wr_en(wgt_wr_en_b), .wgt_wr_addr(wgt_wr_addr_b),
        .conv_en(conv_en_b), .conv_base(conv_base_b), .ofm_wr_addr(ofm_wr_addr_b),
        .pool_en(pool_en_b), .pool_base(pool_base_b), .pool_idx(pool_idx_b),
        .out_valid(out_valid_b), .frame_done(frame_done_b), .busy(busy_b));

    typedef struct {
        int cyc;
        int a;
        int b;
    } ev_t;

    ev_t wq_a[$], cq_a[$], pq_a[$], oq_a[$], dq_a[$];
    ev_t wq_b[$], oq_b[$], dq_b[$];

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   load_cnt[2];
    int   busy_until[2];
    logic exp_rdy[2];
    logic exp_busy[2];
    logic chk_en = 1'b0;
    logic final_req = 1'b0;
    logic final_ack = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Frame model: a frame completes loading at cycle t, then conv runs t+1..t+144,
    // pool t+145..t+180, out_valid lags pool by the latency, and the block is idle from t+181+lat.
    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            int lat = (i == 0) ? 1 : 3;
            exp_rdy[i]  = (cyc >= busy_until[i]);
            exp_busy[i] = (load_cnt[i] > 0) || (cyc < busy_until[i]);
            if (exp_rdy[i] && in_valid) begin
                if (i == 0) wq_a.push_back(ev_t'{cyc: cyc, a: load_cnt[i], b: (load_cnt[i] < 9) ? 1 : 0});
                else        wq_b.push_back(ev_t'{cyc: cyc, a: load_cnt[i], b: 0});
                load_cnt[i]++;
                if (load_cnt[i] == 196) begin
                    load_cnt[i]   = 0;
                    busy_until[i] = cyc + 181 + lat;
                    if (i == 0) begin
                        for (int j = 0; j < 144; j++)
                            cq_a.push_back(ev_t'{cyc: cyc + 1 + j, a: (j / 12) * 14 + (j % 12), b: j});
                        for (int p = 0; p < 36; p++)
                            pq_a.push_back(ev_t'{cyc: cyc + 145 + p, a: (p / 6) * 24 + (p % 6) * 2, b: p});
                    end
                    for (int p = 0; p < 36; p++) begin
                        if (i == 0) oq_a.push_back(ev_t'{cyc: cyc + 145 + p + lat, a: 0, b: 0});
                        else        oq_b.push_back(ev_t'{cyc: cyc + 145 + p + lat, a: 0, b: 0});
                    end
                    if (i == 0) dq_a.push_back(ev_t'{cyc: cyc + 180 + lat, a: 0, b: 0});
                    else        dq_b.push_back(ev_t'{cyc: cyc + 180 + lat, a: 0, b: 0});
                end
            end
        end
    endtask

    task automatic step(input logic v, input logic r);
        @(posedge clk);
        #1;
        in_valid = v;
        rst_n    = r;
        model_step();
        if (!r) begin
            for (int i = 0; i < 2; i++) begin
                load_cnt[i]   = 0;
                busy_until[i] = 0;
            end
        end
        chk_en = 1'b1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0d expected=%0d", nm, cyc, act, exp);
        end
    endtask

    task automatic miss(input string nm, input int exp_cyc);
        checks++;
        failures++;
        $display("FAIL %s cyc=%0d actual=absent expected_at=%0d", nm, cyc, exp_cyc);
    endtask

    ev_t e;
    int  idle_sum;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("a_in_ready", in_ready_a, exp_rdy[0]);
            chk("a_busy", busy_a, exp_busy[0]);
            chk("b_in_ready", in_ready_b, exp_rdy[1]);
            chk("b_busy", busy_b, exp_busy[1]);
            idle_sum = (ifm_wr_en_a ? 0 : ifm_wr_addr_a) + (wgt_wr_en_a ? 0 : wgt_wr_addr_a)
                     + (conv_en_a ? 0 : conv_base_a + ofm_wr_addr_a)
                     + (pool_en_a ? 0 : pool_base_a + pool_idx_a);
            chk("a_idle_addr", idle_sum, 0);

            if (ifm_wr_en_a) begin
                if (wq_a.size() == 0) miss("a_unexpected_write", cyc);
                else begin
                    e = wq_a.pop_front();
                    chk("a_ifm_addr", ifm_wr_addr_a, e.a);
                    chk("a_wgt_en", wgt_wr_en_a, e.b);
                    if (e.b != 0) chk("a_wgt_addr", wgt_wr_addr_a, e.a);
                end
            end
            while (wq_a.size() > 0 && wq_a[0].cyc <= cyc) begin
                miss("a_missing_write", wq_a[0].cyc);
                void'(wq_a.pop_front());
            end
            if (ifm_wr_en_b) begin
                if (wq_b.size() == 0) miss("b_unexpected_write", cyc);
                else begin
                    e = wq_b.pop_front();
                    chk("b_ifm_addr", ifm_wr_addr_b, e.a);
                end
            end
            while (wq_b.size() > 0 && wq_b[0].cyc <= cyc) begin
                miss("b_missing_write", wq_b[0].cyc);
                void'(wq_b.pop_front());
            end

            if (conv_en_a) begin
                if (cq_a.size() == 0) miss("a_unexpected_conv", cyc);
                else begin
                    e = cq_a.pop_front();
                    chk("a_conv_cycle", cyc, e.cyc);
                    chk("a_conv_base", conv_base_a, e.a);
                    chk("a_ofm_addr", ofm_wr_addr_a, e.b);
                end
            end
            while (cq_a.size() > 0 && cq_a[0].cyc <= cyc) begin
                miss("a_missing_conv", cq_a[0].cyc);
                void'(cq_a.pop_front());
            end

            if (pool_en_a) begin
                if (pq_a.size() == 0) miss("a_unexpected_pool", cyc);
                else begin
                    e = pq_a.pop_front();
                    chk("a_pool_cycle", cyc, e.cyc);
                    chk("a_pool_base", pool_base_a, e.a);
                    chk("a_pool_idx", pool_idx_a, e.b);
                end
            end
            while (pq_a.size() > 0 && pq_a[0].cyc <= cyc) begin
                miss("a_missing_pool", pq_a[0].cyc);
                void'(pq_a.pop_front());
            end

            if (out_valid_a) begin
                if (oq_a.size() == 0) miss("a_unexpected_out_valid", cyc);
                else begin e = oq_a.pop_front(); chk("a_out_valid_cycle", cyc, e.cyc); end
            end
            while (oq_a.size() > 0 && oq_a[0].cyc <= cyc) begin
                miss("a_missing_out_valid", oq_a[0].cyc);
                void'(oq_a.pop_front());
            end
            if (out_valid_b) begin
                if (oq_b.size() == 0) miss("b_unexpected_out_valid", cyc);
                else begin e = oq_b.pop_front(); chk("b_out_valid_cycle", cyc, e.cyc); end
            end
            while (oq_b.size() > 0 && oq_b[0].cyc <= cyc) begin
                miss("b_missing_out_valid", oq_b[0].cyc);
                void'(oq_b.pop_front());
            end

            if (frame_done_a) begin
                if (dq_a.size() == 0) miss("a_unexpected_frame_done", cyc);
                else begin e = dq_a.pop_front(); chk("a_frame_done_cycle", cyc, e.cyc); end
            end
            while (dq_a.size() > 0 && dq_a[0].cyc <= cyc) begin
                miss("a_missing_frame_done", dq_a[0].cyc);
                void'(dq_a.pop_front());
            end
            if (frame_done_b) begin
                if (dq_b.size() == 0) miss("b_unexpected_frame_done", cyc);
                else begin e = dq_b.pop_front(); chk("b_frame_done_cycle", cyc, e.cyc); end
            end
            while (dq_b.size() > 0 && dq_b[0].cyc <= cyc) begin
                miss("b_missing_frame_done", dq_b[0].cyc);
                void'(dq_b.pop_front());
            end

            if (final_req && !final_ack) begin
                chk("pending_events", wq_a.size() + cq_a.size() + pq_a.size() + oq_a.size()
                    + dq_a.size() + wq_b.size() + oq_b.size() + dq_b.size(), 0);
                final_ack = 1'b1;
            end
        end
    end

    initial begin
        in_valid = 1'b0;
        rst_n    = 1'b0;
        for (int i = 0; i < 2; i++) begin
            load_cnt[i]   = 0;
            busy_until[i] = 0;
        end
        repeat (3) @(posedge clk);

        // Nominal continuous frame.
        repeat (4) step(1'b0, 1'b1);
        for (int b = 0; b < 196; b++) step(1'b1, 1'b1);
        repeat (400) step(1'b0, 1'b1);

        // Bubbles after beats 20 and 100.
        for (int b = 0; b < 196; b++) begin
            step(1'b1, 1'b1);
            if (b == 20)  repeat (5) step(1'b0, 1'b1);
            if (b == 100) repeat (3) step(1'b0, 1'b1);
        end
        repeat (400) step(1'b0, 1'b1);

        // Reset at beat 150, then a fresh frame with random bubbles.
        for (int b = 0; b < 150; b++) step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        for (int b = 0; b < 196; b++) begin
            while ($urandom_range(3) == 0) step(1'b0, 1'b1);
            step(1'b1, 1'b1);
        end
        repeat (400) step(1'b0, 1'b1);

        // in_valid held high through CONV/POOL, running straight into a back-to-back second frame.
        repeat (377 + 198) step(1'b1, 1'b1);
        repeat (450) step(1'b0, 1'b1);

        final_req = 1'b1;
        repeat (3) @(posedge clk);
        if (!final_ack) begin
            checks++;
            failures++;
            $display("FAIL final_check actual=not_run required=run");
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
